// File: rtl/weight_pkg.sv
// Shared definitions for the weight loader: FSM state encoding, bank_sel
// codes, bank depths and the start-legality check.
package weight_pkg;

    // Fixed command field widths
    localparam int unsigned BASE_W = 11;
    localparam int unsigned LEN_W  = 12;
    localparam int unsigned SUM_W  = 13;

    // Bank depths in words, held at the width used for the range check
    localparam logic [SUM_W-1:0] DEPTH1 = 13'd2048;
    localparam logic [SUM_W-1:0] DEPTH2 = 13'd256;
    localparam logic [SUM_W-1:0] DEPTH3 = 13'd128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        BANK1       = 2'd0,
        BANK2       = 2'd1,
        BANK3       = 2'd2,
        BANK_ILLEGAL = 2'd3
    } bank_e;

    // A start is legal when the bank exists, the count is non-zero and the
    // whole burst fits in the bank (sum taken at 13 bits so it cannot wrap).
    function automatic logic start_legal(input logic [1:0]        sel,
                                         input logic [BASE_W-1:0] base,
                                         input logic [LEN_W-1:0]  len);
        logic [SUM_W-1:0] end_addr;
        logic [SUM_W-1:0] depth;
        end_addr = SUM_W'(base) + SUM_W'(len);
        case (bank_e'(sel))
            BANK1:   depth = DEPTH1;
            BANK2:   depth = DEPTH2;
            BANK3:   depth = DEPTH3;
            default: depth = '0;
        endcase
        return (bank_e'(sel) != BANK_ILLEGAL) && (len != '0) && (end_addr <= depth);
    endfunction

endpackage

// File: rtl/weight_load_ctrl.sv
// Weight load controller: accepts a (bank, base, length) load command, then
// streams s_data words into the selected SRAM bank write port, one write
// strobe per accepted stream word.
//
// Ports:
//   clk, rst_n                - clock, async active-low reset
//   start/bank_sel/base_addr/length - load command (sampled in IDLE)
//   abort                     - cancels a load while words are being accepted
//   s_valid/s_data/s_ready    - input word stream
//   busy/done/err             - status: active, completion pulse, reject pulse
//   csN_wr/weN_wr/oeN_wr/addrN_wr/dataN_wr - registered bank write ports
module weight_load_ctrl
    import weight_pkg::*;
#(
    parameter int unsigned WEIGHT_WIDTH = 64,
    parameter int unsigned BN_WIDTH     = 16,
    parameter int unsigned ADDR_WIDTH1  = 11,
    parameter int unsigned ADDR_WIDTH2  = 8,
    parameter int unsigned ADDR_WIDTH3  = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              bank_sel,
    input  logic [BASE_W-1:0]       base_addr,
    input  logic [LEN_W-1:0]        length,
    input  logic                    abort,
    input  logic                    s_valid,
    input  logic [WEIGHT_WIDTH-1:0] s_data,
    output logic                    s_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    cs1_wr,
    output logic                    we1_wr,
    output logic                    oe1_wr,
    output logic [ADDR_WIDTH1-1:0]  addr1_wr,
    output logic [WEIGHT_WIDTH-1:0] data1_wr,
    output logic                    cs2_wr,
    output logic                    we2_wr,
    output logic                    oe2_wr,
    output logic [ADDR_WIDTH2-1:0]  addr2_wr,
    output logic [WEIGHT_WIDTH-1:0] data2_wr,
    output logic                    cs3_wr,
    output logic                    we3_wr,
    output logic                    oe3_wr,
    output logic [ADDR_WIDTH3-1:0]  addr3_wr,
    output logic [BN_WIDTH-1:0]     data3_wr
);

    state_e                  state_q, state_d;
    bank_e                   bank_q, bank_d;
    logic [BASE_W-1:0]       addr_q, addr_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    s_ready_q, busy_q, done_q;
    logic                    wr1_q, wr2_q, wr3_q;
    logic [ADDR_WIDTH1-1:0]  addr1_q;
    logic [ADDR_WIDTH2-1:0]  addr2_q;
    logic [ADDR_WIDTH3-1:0]  addr3_q;
    logic [WEIGHT_WIDTH-1:0] data1_q, data2_q;
    logic [BN_WIDTH-1:0]     data3_q;
    logic                    hs_c;
    logic                    legal_c;

    // A word is taken only in WRITE; an abort in the same cycle discards it
    assign hs_c    = (state_q == ST_WRITE) && s_valid && !abort;
    assign legal_c = start_legal(bank_sel, base_addr, length);

    // Next-state and command/counter update
    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (legal_c) begin
                        state_d = ST_WRITE;
                        bank_d  = bank_e'(bank_sel);
                        addr_d  = base_addr;
                        cnt_d   = length;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (s_valid) begin
                    addr_d = addr_q + BASE_W'(1);
                    cnt_d  = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, status and write-port registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bank_q    <= BANK1;
            addr_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr1_q     <= 1'b0;
            wr2_q     <= 1'b0;
            wr3_q     <= 1'b0;
            addr1_q   <= '0;
            addr2_q   <= '0;
            addr3_q   <= '0;
            data1_q   <= '0;
            data2_q   <= '0;
            data3_q   <= '0;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            s_ready_q <= (state_d == ST_WRITE);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
            wr1_q     <= hs_c && (bank_q == BANK1);
            wr2_q     <= hs_c && (bank_q == BANK2);
            wr3_q     <= hs_c && (bank_q == BANK3);
            // Address/data of a bank only move when that bank is written
            if (hs_c && (bank_q == BANK1)) begin
                addr1_q <= ADDR_WIDTH1'(addr_q);
                data1_q <= s_data;
            end
            if (hs_c && (bank_q == BANK2)) begin
                addr2_q <= ADDR_WIDTH2'(addr_q);
                data2_q <= s_data;
            end
            if (hs_c && (bank_q == BANK3)) begin
                addr3_q <= ADDR_WIDTH3'(addr_q);
                data3_q <= BN_WIDTH'(s_data);
            end
        end
    end

    assign s_ready  = s_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

    // Chip select and write enable are the same strobe; read enable never used
    assign cs1_wr   = wr1_q;
    assign we1_wr   = wr1_q;
    assign oe1_wr   = 1'b0;
    assign addr1_wr = addr1_q;
    assign data1_wr = data1_q;

    assign cs2_wr   = wr2_q;
    assign we2_wr   = wr2_q;
    assign oe2_wr   = 1'b0;
    assign addr2_wr = addr2_q;
    assign data2_wr = data2_q;

    assign cs3_wr   = wr3_q;
    assign we3_wr   = wr3_q;
    assign oe3_wr   = 1'b0;
    assign addr3_wr = addr3_q;
    assign data3_wr = data3_q;

endmodule
